// File: rtl/fc_pkg.sv
// Shared types and helpers for the FC + argmax engine: FSM state type,
// clog2, and 64-bit sign-extension / saturation used by the datapath.
package fc_pkg;

  typedef enum logic [2:0] {
    ST_ACC,
    ST_BIAS,
    ST_SCALE,
    ST_SCAN,
    ST_DONE
  } fc_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r++;
    end
    return r;
  endfunction

  // Treat the low bw bits of v as signed and widen to 64 bits.
  function automatic logic signed [63:0] sext(input logic [63:0] v, input int unsigned bw);
    logic signed [63:0] t;
    t = $signed(v << (64 - bw));
    return t >>> (64 - bw);
  endfunction

  // Clamp v into the signed range of a bw-bit value.
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int unsigned bw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (bw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fc_argmax_engine_if.sv
// Element-stream and result handshake bundle for fc_argmax_engine.
interface fc_argmax_engine_if
  import fc_pkg::*;
#(
  parameter int unsigned I_BW = 16,
  parameter int unsigned O_BW = 16,
  parameter int unsigned CO   = 10
);
  localparam int unsigned CLS_BW = clog2(CO);

  logic              i_valid;
  logic              o_ready;
  logic [I_BW-1:0]   i_data;
  logic              o_valid;
  logic              i_out_ready;
  logic [CLS_BW-1:0] o_class;
  logic [O_BW-1:0]   o_score;

  modport slave (
    input  i_valid, i_data, i_out_ready,
    output o_ready, o_valid, o_class, o_score
  );

  modport master (
    output i_valid, i_data, i_out_ready,
    input  o_ready, o_valid, o_class, o_score
  );
endinterface

// File: rtl/fc_argmax_scan.sv
// Sequential argmax over a CO x O_BW signed score bus; ties keep the lowest
// index. class_o/score_o carry the post-compare result, valid with done_o.
module fc_argmax_scan
  import fc_pkg::*;
#(
  parameter int unsigned CO   = 10,
  parameter int unsigned O_BW = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clr_i,
  input  logic                      start_i,
  input  logic [CO*O_BW-1:0]        scores_i,
  output logic                      done_o,
  output logic [clog2(CO)-1:0]      class_o,
  output logic signed [O_BW-1:0]    score_o
);
  localparam int unsigned CLS_BW = clog2(CO);
  localparam logic [CLS_BW-1:0] LAST = CLS_BW'(CO - 1);

  logic                     busy_q, busy_d;
  logic [CLS_BW-1:0]        idx_q, idx_d;
  logic [CLS_BW-1:0]        cls_q, cls_d;
  logic signed [O_BW-1:0]   best_q, best_d;
  logic [CLS_BW-1:0]        nidx;
  logic signed [O_BW-1:0]   cand;
  logic                     take;

  // Compare path is independent of start_i so the top can consume it freely.
  always_comb begin
    nidx    = idx_q + CLS_BW'(1);
    cand    = scores_i[32'(nidx)*O_BW +: O_BW];
    take    = busy_q && (cand > best_q);
    class_o = take ? nidx : cls_q;
    score_o = take ? cand : best_q;
    done_o  = busy_q && (nidx == LAST);
  end

  always_comb begin
    busy_d = busy_q;
    idx_d  = idx_q;
    cls_d  = class_o;
    best_d = score_o;
    if (clr_i) begin
      busy_d = 1'b0;
      idx_d  = '0;
      cls_d  = '0;
      best_d = '0;
    end else if (start_i) begin
      busy_d = 1'b1;
      idx_d  = '0;
      cls_d  = '0;
      best_d = scores_i[O_BW-1:0];
    end else if (busy_q) begin
      idx_d = nidx;
      if (done_o) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
      idx_q  <= '0;
      cls_q  <= '0;
      best_q <= '0;
    end else begin
      busy_q <= busy_d;
      idx_q  <= idx_d;
      cls_q  <= cls_d;
      best_q <= best_d;
    end
  end

endmodule

// File: rtl/fc_argmax_engine.sv
// Fully-connected output layer with bias, rescale/saturate and argmax.
// Build option: define FC_RELU_EN to clamp negative scores to zero.
module fc_argmax_engine
  import fc_pkg::*;
#(
  parameter int unsigned I_BW       = 16,
  parameter int unsigned W_BW       = 8,
  parameter int unsigned B_BW       = 16,
  parameter int unsigned O_BW       = 16,
  parameter int unsigned ACC_BW     = 32,
  parameter int unsigned N_IN       = 192,
  parameter int unsigned CO         = 10,
  parameter int unsigned FRAC_SHIFT = 16
) (
  input  logic                       clk,
  input  logic                       global_rst_n,
  input  logic                       user_reset,
  fc_argmax_engine_if.slave          bus,
  input  logic [CO*N_IN*W_BW-1:0]    i_weight,
  input  logic [CO*B_BW-1:0]         i_bias,
  output logic                       o_busy
);
  localparam int unsigned CLS_BW  = clog2(CO);
  localparam int unsigned CNT_BW  = (clog2(N_IN) < 1) ? 1 : clog2(N_IN);
  localparam int unsigned PROD_BW = I_BW + W_BW;
  localparam logic [CNT_BW-1:0] CNT_LAST = CNT_BW'(N_IN - 1);

  fc_state_e            state_q, state_d;
  logic [CNT_BW-1:0]    cnt_q, cnt_d;
  logic [ACC_BW-1:0]    acc_q [CO];
  logic [ACC_BW-1:0]    acc_d [CO];
  logic [O_BW-1:0]      score_q [CO];
  logic [O_BW-1:0]      score_d [CO];
  logic [CLS_BW-1:0]    cls_q, cls_d;
  logic [O_BW-1:0]      oscore_q, oscore_d;

  logic [W_BW-1:0]      w_sel;
  logic [PROD_BW-1:0]   prod;
  logic signed [63:0]   scaled;
  logic [CO*O_BW-1:0]   scores_flat;
  logic                 scan_start;
  logic                 scan_done;
  logic [CLS_BW-1:0]    scan_cls;
  logic signed [O_BW-1:0] scan_score;

  assign bus.o_ready = (state_q == ST_ACC) && global_rst_n;
  assign bus.o_valid = (state_q == ST_DONE);
  assign bus.o_class = cls_q;
  assign bus.o_score = oscore_q;
  assign o_busy      = !((state_q == ST_ACC) && (cnt_q == '0));

  // Scores are computed combinationally in SCALE and fed straight to the
  // scanner so it can seed best=score[0] on the same edge they are stored.
  always_comb begin
    score_d = score_q;
    scaled  = '0;
    if (user_reset) begin
      for (int unsigned c = 0; c < CO; c++) score_d[c] = '0;
    end else if (state_q == ST_SCALE) begin
      for (int unsigned c = 0; c < CO; c++) begin
        scaled = sat(sext(64'(acc_q[c]), ACC_BW) >>> FRAC_SHIFT, O_BW);
`ifdef FC_RELU_EN
        if (scaled < 0) scaled = '0;
`endif
        score_d[c] = O_BW'(scaled);
      end
    end
  end

  always_comb begin
    scores_flat = '0;
    for (int unsigned c = 0; c < CO; c++) scores_flat[c*O_BW +: O_BW] = score_d[c];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    cls_d      = cls_q;
    oscore_d   = oscore_q;
    scan_start = 1'b0;
    w_sel      = '0;
    prod       = '0;
    if (user_reset) begin
      state_d  = ST_ACC;
      cnt_d    = '0;
      cls_d    = '0;
      oscore_d = '0;
      for (int unsigned c = 0; c < CO; c++) acc_d[c] = '0;
    end else begin
      unique case (state_q)
        ST_ACC: begin
          if (bus.i_valid) begin
            for (int unsigned c = 0; c < CO; c++) begin
              w_sel    = i_weight[(c*N_IN + 32'(cnt_q))*W_BW +: W_BW];
              prod     = {{W_BW{bus.i_data[I_BW-1]}}, bus.i_data}
                       * {{I_BW{w_sel[W_BW-1]}}, w_sel};
              acc_d[c] = acc_q[c] + ACC_BW'(sext(64'(prod), PROD_BW));
            end
            if (cnt_q == CNT_LAST) begin
              cnt_d   = '0;
              state_d = ST_BIAS;
            end else begin
              cnt_d = cnt_q + CNT_BW'(1);
            end
          end
        end
        ST_BIAS: begin
          for (int unsigned c = 0; c < CO; c++)
            acc_d[c] = acc_q[c] + ACC_BW'(sext(64'(i_bias[c*B_BW +: B_BW]), B_BW));
          state_d = ST_SCALE;
        end
        ST_SCALE: begin
          scan_start = 1'b1;
          state_d    = ST_SCAN;
        end
        ST_SCAN: begin
          if (scan_done) begin
            cls_d    = scan_cls;
            oscore_d = scan_score;
            state_d  = ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.i_out_ready) begin
            state_d = ST_ACC;
            for (int unsigned c = 0; c < CO; c++) acc_d[c] = '0;
          end
        end
        default: state_d = ST_ACC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      state_q  <= ST_ACC;
      cnt_q    <= '0;
      cls_q    <= '0;
      oscore_q <= '0;
      for (int unsigned c = 0; c < CO; c++) begin
        acc_q[c]   <= '0;
        score_q[c] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cls_q    <= cls_d;
      oscore_q <= oscore_d;
      acc_q    <= acc_d;
      score_q  <= score_d;
    end
  end

  fc_argmax_scan #(
    .CO   (CO),
    .O_BW (O_BW)
  ) u_scan (
    .clk_i    (clk),
    .rst_ni   (global_rst_n),
    .clr_i    (user_reset),
    .start_i  (scan_start),
    .scores_i (scores_flat),
    .done_o   (scan_done),
    .class_o  (scan_cls),
    .score_o  (scan_score)
  );

endmodule

// File: tb/tb_fc_argmax_engine.sv
// Directed bench for fc_argmax_engine (N_IN=4, CO=3) with FRAC_SHIFT=0 and 10 instances.
module tb_fc_argmax_engine;
  localparam int unsigned N_IN = 4;
  localparam int unsigned CO   = 3;
  localparam int unsigned LAT  = CO + 2;
`ifdef FC_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic clk = 1'b0;
  logic global_rst_n;
  logic user_reset;
  logic [CO*N_IN*8-1:0] wbus;
  logic [CO*16-1:0]     bbus;
  logic busy0, busy10;

  always #5 clk = ~clk;

  fc_argmax_engine_if #(.I_BW(16), .O_BW(16), .CO(CO)) bus0 ();
  fc_argmax_engine_if #(.I_BW(16), .O_BW(16), .CO(CO)) bus10 ();

  assign bus10.i_valid     = bus0.i_valid;
  assign bus10.i_data      = bus0.i_data;
  assign bus10.i_out_ready = bus0.i_out_ready;

  fc_argmax_engine #(.N_IN(N_IN), .CO(CO), .FRAC_SHIFT(0)) u_dut (
    .clk(clk), .global_rst_n(global_rst_n), .user_reset(user_reset), .bus(bus0),
    .i_weight(wbus), .i_bias(bbus), .o_busy(busy0));

  fc_argmax_engine #(.N_IN(N_IN), .CO(CO), .FRAC_SHIFT(10)) u_dut10 (
    .clk(clk), .global_rst_n(global_rst_n), .user_reset(user_reset), .bus(bus10),
    .i_weight(wbus), .i_bias(bbus), .o_busy(busy10));

  typedef struct {
    int d[4];
    int w[3][4];
    int b[3];
    int cls;
    int score;
    int cls10;
    int score10;
  } vec_t;

  vec_t vecs[8];
  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load(input int k);
    for (int c = 0; c < 3; c++) begin
      bbus[c*16 +: 16] = 16'(vecs[k].b[c]);
      for (int n = 0; n < 4; n++) wbus[(c*4 + n)*8 +: 8] = 8'(vecs[k].w[c][n]);
    end
  endtask

  // Sends elements first..last; returns at the negedge after the last accept.
  task automatic send(input int k, input int first, input int last, input bit gaps);
    for (int n = first; n <= last; n++) begin
      int g;
      int t;
      g = gaps ? int'($urandom_range(0, 3)) : 0;
      repeat (g) @(negedge clk);
      bus0.i_valid = 1'b1;
      bus0.i_data  = 16'(vecs[k].d[n]);
      t = 0;
      while (!bus0.o_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t >= 50) chk("ready_timeout", 0, 1);
      @(posedge clk);
      @(negedge clk);
      bus0.i_valid = 1'b0;
    end
  endtask

  task automatic wait_result(input int k, input bit release_chk);
    int lat;
    lat = 1;
    while (!bus0.o_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, LAT);
    chk("class", int'(bus0.o_class), vecs[k].cls);
    chk("score", int'($signed(bus0.o_score)), vecs[k].score);
    chk("class_sh10", int'(bus10.o_class), vecs[k].cls10);
    chk("score_sh10", int'($signed(bus10.o_score)), vecs[k].score10);
    if (release_chk) begin
      @(negedge clk);
      chk("valid_drop", int'(bus0.o_valid), 0);
      chk("ready_back", int'(bus0.o_ready), 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0].d = '{1, 1, 1, 1};
    vecs[0].w = '{'{1, 1, 1, 1}, '{2, 2, 2, 2}, '{3, 3, 3, 3}};
    vecs[0].b = '{0, 0, 0};
    vecs[0].cls = 2; vecs[0].score = 12; vecs[0].cls10 = 0; vecs[0].score10 = 0;

    vecs[1].d = '{3, 3, 3, 3};
    vecs[1].w = '{'{2, 2, 2, 2}, '{2, 2, 2, 2}, '{2, 2, 2, 2}};
    vecs[1].b = '{0, 0, 0};
    vecs[1].cls = 0; vecs[1].score = 24; vecs[1].cls10 = 0; vecs[1].score10 = 0;

    vecs[2].d = '{1, 1, 1, 1};
    vecs[2].w = '{'{-1, -1, -1, -1}, '{-2, -2, -2, -2}, '{-3, -3, -3, -3}};
    vecs[2].b = '{0, 0, 0};
    vecs[2].cls = 0; vecs[2].score = RELU ? 0 : -4;
    vecs[2].cls10 = 0; vecs[2].score10 = RELU ? 0 : -1;

    // 32767*127*4 - 1 = 16645635; >>>10 gives 16255
    vecs[3].d = '{32767, 32767, 32767, 32767};
    vecs[3].w = '{'{127, 127, 127, 127}, '{127, 127, 127, 127}, '{127, 127, 127, 127}};
    vecs[3].b = '{-1, -1, -1};
    vecs[3].cls = 0; vecs[3].score = 32767; vecs[3].cls10 = 0; vecs[3].score10 = 16255;

    vecs[4].d = '{2, -3, 5, -1};
    vecs[4].w = '{'{1, 1, 1, 1}, '{3, -2, 0, 4}, '{-1, -1, 2, 0}};
    vecs[4].b = '{0, 10, -5};
    vecs[4].cls = 1; vecs[4].score = 18; vecs[4].cls10 = 0; vecs[4].score10 = 0;

    vecs[5].d = '{1, 1, 1, 1};
    vecs[5].w = '{'{0, 0, 0, 0}, '{1, 1, 1, 1}, '{1, 1, 1, 1}};
    vecs[5].b = '{-100, 5, 5};
    vecs[5].cls = 1; vecs[5].score = 9; vecs[5].cls10 = RELU ? 0 : 1; vecs[5].score10 = 0;

    vecs[6].d = '{-32768, -32768, -32768, -32768};
    vecs[6].w = '{'{127, 127, 127, 127}, '{-128, -128, -128, -128}, '{0, 0, 0, 0}};
    vecs[6].b = '{0, 0, 0};
    vecs[6].cls = 1; vecs[6].score = 32767; vecs[6].cls10 = 1; vecs[6].score10 = 16384;

    vecs[7].d = '{1, 2, 3, 4};
    vecs[7].w = '{'{0, 0, 0, 0}, '{0, 0, 0, 0}, '{1, 1, 1, 1}};
    vecs[7].b = '{0, 0, -3};
    vecs[7].cls = 2; vecs[7].score = 7; vecs[7].cls10 = 0; vecs[7].score10 = 0;

    bus0.i_valid     = 1'b0;
    bus0.i_data      = '0;
    bus0.i_out_ready = 1'b1;
    user_reset       = 1'b0;
    global_rst_n     = 1'b1;
    load(0);
    #2 global_rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", int'(bus0.o_ready), 0);
    chk("rst_valid", int'(bus0.o_valid), 0);
    chk("rst_class", int'(bus0.o_class), 0);
    chk("rst_score", int'(bus0.o_score), 0);
    chk("rst_busy", int'(busy0), 0);
    global_rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", int'(bus0.o_ready), 1);

    for (int k = 0; k < 8; k++) begin
      load(k);
      send(k, 0, 3, 1'b0);
      wait_result(k, 1'b1);
    end

    load(0);
    send(0, 0, 3, 1'b1);
    wait_result(0, 1'b1);
    load(4);
    send(4, 0, 3, 1'b1);
    wait_result(4, 1'b1);

    // Held result under back-pressure; stray i_valid must not be consumed.
    bus0.i_out_ready = 1'b0;
    load(0);
    send(0, 0, 3, 1'b0);
    wait_result(0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      bus0.i_valid = 1'b1;
      bus0.i_data  = 16'(77);
      @(negedge clk);
      chk("hold_valid", int'(bus0.o_valid), 1);
      chk("hold_class", int'(bus0.o_class), 2);
      chk("hold_score", int'(bus0.o_score), 12);
      chk("hold_ready", int'(bus0.o_ready), 0);
    end
    bus0.i_valid     = 1'b0;
    bus0.i_out_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid_drop", int'(bus0.o_valid), 0);
    chk("bp_busy_clear", int'(busy0), 0);
    chk("bp_class_kept", int'(bus0.o_class), 2);

    // user_reset after two elements discards the partial sums.
    load(3);
    send(3, 0, 1, 1'b0);
    chk("partial_busy", int'(busy0), 1);
    user_reset   = 1'b1;
    bus0.i_valid = 1'b1;
    bus0.i_data  = 16'(1000);
    @(negedge clk);
    user_reset   = 1'b0;
    bus0.i_valid = 1'b0;
    chk("ureset_busy", int'(busy0), 0);
    chk("ureset_class", int'(bus0.o_class), 0);
    load(4);
    send(4, 0, 3, 1'b0);
    wait_result(4, 1'b1);

    // Async reset during SCAN clears outputs immediately.
    load(0);
    send(0, 0, 3, 1'b0);
    repeat (2) @(negedge clk);
    chk("pre_rst_class", int'(bus0.o_class), 1);
    global_rst_n = 1'b0;
    #1;
    chk("async_valid", int'(bus0.o_valid), 0);
    chk("async_class", int'(bus0.o_class), 0);
    chk("async_score", int'(bus0.o_score), 0);
    chk("async_ready", int'(bus0.o_ready), 0);
    chk("async_busy", int'(busy0), 0);
    repeat (2) @(negedge clk);
    global_rst_n = 1'b1;
    @(negedge clk);
    chk("rerst_ready", int'(bus0.o_ready), 1);
    chk("rerst_valid", int'(bus0.o_valid), 0);
    load(7);
    send(7, 0, 3, 1'b0);
    wait_result(7, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
